// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared channel-state type and index-width helper for the clk_div_bank slice.
//   CHAN_DIV_W   width of half-period and counter fields held per channel
//   chan_state_t per-channel register state (current/pending half-period, counter, clock bit)
//   ch_idx_w()   channel-select width, never below 1
package clk_div_pkg;
    localparam int CHAN_DIV_W = 8;
    typedef struct packed {
        logic [CHAN_DIV_W-1:0] cur_div;
        logic [CHAN_DIV_W-1:0] cnt;
        logic [CHAN_DIV_W-1:0] pend_div;
        logic                  pend_vld;
        logic                  clk_q;
    } chan_state_t;
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divided-clock channel with programmable half-period and glitch-free reload.
//   clk, rst_n  top-level clock, asynchronous active-low reset
//   wr_i        accepted config transfer aimed at this channel
//   wr_div_i    new half-period carried by the transfer (0 disables)
//   sync_i      restart the channel low with counter cleared
//   div_clk_o   registered divided clock
//   div_tick_o  one-cycle pulse on each div_clk_o rise
//   active_o    current half-period is non-zero
//   pend_o      a config is waiting for its apply point
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter logic [CHAN_DIV_W-1:0] RESET_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [CHAN_DIV_W-1:0] wr_div_i,
    input  logic                  sync_i,
    output logic                  div_clk_o,
    output logic                  div_tick_o,
    output logic                  active_o,
    output logic                  pend_o
);
    chan_state_t s_q, s_d;
    logic        tick_q, tick_d;
    logic        last, apply;
    assign last  = s_q.cnt == s_q.cur_div - CHAN_DIV_W'(1);
    // Reload only while low-going or idle so the new period never clips a high phase.
    assign apply = s_q.pend_vld && (sync_i || s_q.cur_div == '0 || (s_q.clk_q && last));
    always_comb begin
        s_d = s_q;
        if (apply) begin
            s_d.cur_div  = s_q.pend_div;
            s_d.cnt      = '0;
            s_d.clk_q    = 1'b0;
            s_d.pend_vld = 1'b0;
        end else if (s_q.cur_div == '0) begin
            s_d.cnt   = '0;
            s_d.clk_q = 1'b0;
        end else begin
            s_d.cnt   = last ? '0 : s_q.cnt + CHAN_DIV_W'(1);
            s_d.clk_q = last ? !s_q.clk_q : s_q.clk_q;
        end
        if (sync_i) begin
            s_d.cnt   = '0;
            s_d.clk_q = 1'b0;
        end
        // A same-cycle write lands after any apply, so it stays pending.
        if (wr_i) begin
            s_d.pend_div = wr_div_i;
            s_d.pend_vld = 1'b1;
        end
        tick_d = s_d.clk_q && !s_q.clk_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '{cur_div: RESET_DIV, cnt: '0, pend_div: '0, pend_vld: 1'b0, clk_q: 1'b0};
            tick_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            tick_q <= tick_d;
        end
    end
    assign div_clk_o  = s_q.clk_q;
    assign div_tick_o = tick_q;
    assign active_o   = s_q.cur_div != '0;
    assign pend_o     = s_q.pend_vld;
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH independent divided clocks with a valid/ready config port and global sync.
//   clk, rst_n            top-level clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   config handshake; ready depends only on cfg_ch and channel state
//   cfg_ch, cfg_div       target channel and new half-period (0 disables)
//   cfg_err               pulse the cycle after a transfer to a nonexistent channel
//   sync                  phase-align every channel
//   div_clk, div_tick     divided clocks and their rising-edge ticks
//   active, busy          per-channel enabled flag, any config pending
// Channel state width is CHAN_DIV_W; DIV_W sizes the port and should match it.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = CHAN_DIV_W,
    parameter int RESET_DIV = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    output logic                        cfg_err,
    input  logic                        sync,
    output logic [NUM_CH-1:0]           div_clk,
    output logic [NUM_CH-1:0]           div_tick,
    output logic [NUM_CH-1:0]           active,
    output logic                        busy
);
    localparam int IW  = ch_idx_w(NUM_CH);
    localparam int PAD = 1 << IW;
    logic [NUM_CH-1:0] pend;
    logic [PAD-1:0]    pend_pad;
    logic              xfer, in_rng, err_q, err_d;
    // Unused select codes read as "not pending", so out-of-range requests are always accepted.
    assign pend_pad  = PAD'(pend);
    assign cfg_ready = !pend_pad[cfg_ch];
    assign in_rng    = 32'(cfg_ch) < NUM_CH;
    assign xfer      = cfg_valid && cfg_ready;
    assign err_d     = xfer && !in_rng;
    assign busy      = |pend;
    assign cfg_err   = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(.RESET_DIV(CHAN_DIV_W'(RESET_DIV))) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_i       (xfer && cfg_ch == IW'(i)),
            .wr_div_i   (CHAN_DIV_W'(cfg_div)),
            .sync_i     (sync),
            .div_clk_o  (div_clk[i]),
            .div_tick_o (div_tick[i]),
            .active_o   (active[i]),
            .pend_o     (pend[i])
        );
    end
endmodule
